// File: rtl/playback_sample_buffer.sv
// ---------------------------------------------------------------------------
// playback_sample_buffer : single-bank fill/drain sample store feeding I2S TX
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module playback_sample_buffer #(
  parameter int DATA_W = 24,
  parameter int DEPTH  = 1024,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              wr_valid_i,
  output logic              wr_ready_o,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_valid_o,
  input  logic              rd_ready_i,
  output logic              buffer_ready_o,
  input  logic              loop_i,
  input  logic              flush_i,
  output logic [AW:0]       level_o,
  output logic              overflow_o,
  output logic [15:0]       drop_count_o,
  output logic [1:0]        state_o
);

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [AW-1:0] LAST_ADDR  = AW'(DEPTH - 1);
  localparam logic [AW:0]   LEVEL_FULL = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   LEVEL_ONE  = (AW + 1)'(1);

  state_t            state, state_nxt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr, rd_addr;
  logic              wr_en, rd_en, rd_fire, last_rd, drop_event;

  assign wr_ready_o = (state == FILL);
  assign state_o    = state;

  assign wr_en      = rst_ni & ~flush_i & wr_valid_i & (state == FILL);
  assign drop_event = ~flush_i & wr_valid_i & (state != FILL);
  assign rd_fire    = (state == DRAIN) & rd_valid_o & rd_ready_i;
  assign last_rd    = (level_o == LEVEL_ONE);
  // LOAD always fetches word 0; DRAIN prefetches the next word on each handshake
  assign rd_en      = (state == LOAD) | (rd_fire & ~last_rd);
  assign rd_addr    = (state == LOAD) ? '0 : rd_ptr;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) state <= FILL;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FILL:    if (wr_en && wr_ptr == LAST_ADDR) state_nxt = LOAD;
      LOAD:    state_nxt = DRAIN;
      DRAIN:   if (rd_fire && last_rd) state_nxt = loop_i ? LOAD : FILL;
      default: state_nxt = FILL;
    endcase
    if (flush_i) state_nxt = FILL;
  end

  // Storage array without reset so it maps onto block RAM
  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_ptr] <= wr_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni)                rd_data_o <= '0;
    else if (rd_en && !flush_i) rd_data_o <= mem[rd_addr];
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      level_o        <= '0;
      rd_valid_o     <= 1'b0;
      buffer_ready_o <= 1'b0;
      overflow_o     <= 1'b0;
      drop_count_o   <= '0;
    end else begin
      buffer_ready_o <= 1'b0;
      if (drop_event) begin
        overflow_o <= 1'b1;
        if (drop_count_o != 16'hFFFF) drop_count_o <= drop_count_o + 16'd1;
      end
      case (state)
        FILL: begin
          if (wr_en) begin
            level_o <= level_o + 1'b1;
            wr_ptr  <= (wr_ptr == LAST_ADDR) ? '0 : wr_ptr + 1'b1;
          end
        end
        LOAD: begin
          rd_ptr         <= AW'(1);
          rd_valid_o     <= 1'b1;
          buffer_ready_o <= 1'b1;
          level_o        <= LEVEL_FULL;
        end
        DRAIN: begin
          if (rd_fire) begin
            if (!last_rd) begin
              rd_ptr  <= rd_ptr + 1'b1;
              level_o <= level_o - 1'b1;
            end else begin
              rd_ptr     <= '0;
              rd_valid_o <= 1'b0;
              level_o    <= loop_i ? LEVEL_FULL : '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_playback_sample_buffer.sv
// ---------------------------------------------------------------------------
// tb_playback_sample_buffer : directed scoreboard bench, DEPTH=4
// ---------------------------------------------------------------------------
`default_nettype none

module tb_playback_sample_buffer;

  localparam int DATA_W = 24;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              wr_valid = 1'b0;
  logic              wr_ready;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              rd_ready = 1'b0;
  logic              buffer_ready;
  logic              loop_en = 1'b0;
  logic              flush = 1'b0;
  logic [2:0]        level;
  logic              overflow;
  logic [15:0]       drop_count;
  logic [1:0]        state;

  int vectors = 0;
  int miscompares = 0;
  int br_count = 0;
  int br0;
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] bank [DEPTH];
  logic              held_v = 1'b0;
  logic [DATA_W-1:0] held_d = '0;

  playback_sample_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .wr_data_i      (wr_data),
    .wr_valid_i     (wr_valid),
    .wr_ready_o     (wr_ready),
    .rd_data_o      (rd_data),
    .rd_valid_o     (rd_valid),
    .rd_ready_i     (rd_ready),
    .buffer_ready_o (buffer_ready),
    .loop_i         (loop_en),
    .flush_i        (flush),
    .level_o        (level),
    .overflow_o     (overflow),
    .drop_count_o   (drop_count),
    .state_o        (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Read-side scoreboard, sampled mid-cycle
  always @(negedge clk) begin
    if (rst_n && !flush) begin
      if (buffer_ready) br_count++;
      if (held_v) begin
        chk("rd_valid_hold", {31'd0, rd_valid}, 32'd1);
        if (rd_valid) chk("rd_stable", {8'd0, rd_data}, {8'd0, held_d});
      end
      held_v = rd_valid && !rd_ready;
      held_d = rd_data;
      if (rd_valid && rd_ready) begin
        chk("rd_extra", {31'd0, exp_q.size() > 0}, 32'd1);
        if (exp_q.size() > 0) chk("rd_data", {8'd0, rd_data}, {8'd0, exp_q.pop_front()});
      end
    end else begin
      held_v = 1'b0;
    end
  end

  task automatic write_n(input int first, input int n);
    for (int i = first; i < first + n; i++) begin
      wr_valid = 1'b1;
      wr_data  = bank[i];
      exp_q.push_back(bank[i]);
      tick();
    end
    wr_valid = 1'b0;
  endtask

  task automatic wait_br();
    for (int i = 0; i < 20; i++) begin
      if (buffer_ready) break;
      tick();
    end
    chk("br_seen", {31'd0, buffer_ready}, 32'd1);
    chk("rd_valid_with_br", {31'd0, rd_valid}, 32'd1);
  endtask

  task automatic drain_bank(input bit bp, input bit chk_lvl);
    int  done;
    bit  hs;
    done = 0;
    for (int cyc = 0; cyc < 200 && done < DEPTH; cyc++) begin
      rd_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      hs = rd_valid && rd_ready;
      tick();
      if (hs) done++;
      if (chk_lvl) chk("level", {29'd0, level}, 32'(DEPTH - done));
    end
    rd_ready = 1'b0;
    chk("hs_count", 32'(done), 32'(DEPTH));
  endtask

  task automatic check_reset_values();
    chk("rst_rd_data", {8'd0, rd_data}, 32'd0);
    chk("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    chk("rst_br", {31'd0, buffer_ready}, 32'd0);
    chk("rst_level", {29'd0, level}, 32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    chk("rst_drop", {16'd0, drop_count}, 32'd0);
    chk("rst_state", {30'd0, state}, 32'd0);
    chk("rst_wr_ready", {31'd0, wr_ready}, 32'd1);
  endtask

  initial begin
    // Reset
    tick(); tick();
    check_reset_values();
    rst_n = 1'b1;
    tick();

    // Fill/drain with exact latency
    bank[0] = 24'h000001; bank[1] = 24'h7FFFFF; bank[2] = 24'h800000; bank[3] = 24'hFFFFFF;
    br0 = br_count;
    rd_ready = 1'b1;
    write_n(0, 4);
    chk("t1_load_state", {30'd0, state}, 32'd1);
    chk("t1_load_br", {31'd0, buffer_ready}, 32'd0);
    chk("t1_load_wr_ready", {31'd0, wr_ready}, 32'd0);
    chk("t1_load_level", {29'd0, level}, 32'd4);
    tick();
    chk("t1_br", {31'd0, buffer_ready}, 32'd1);
    chk("t1_rd_valid", {31'd0, rd_valid}, 32'd1);
    chk("t1_level_full", {29'd0, level}, 32'd4);
    drain_bank(1'b0, 1'b1);
    chk("t1_rd_valid_end", {31'd0, rd_valid}, 32'd0);
    chk("t1_wr_ready_end", {31'd0, wr_ready}, 32'd1);
    chk("t1_q_empty", 32'(exp_q.size()), 32'd0);
    chk("t1_br_pulses", 32'(br_count - br0), 32'd1);

    // Read backpressure
    bank[0] = 24'h123456; bank[1] = 24'hABCDEF; bank[2] = 24'h000000; bank[3] = 24'h5A5A5A;
    write_n(0, 4);
    wait_br();
    drain_bank(1'b1, 1'b1);
    chk("t2_state", {30'd0, state}, 32'd0);
    chk("t2_q_empty", 32'(exp_q.size()), 32'd0);

    // Overflow through LOAD/DRAIN
    bank[0] = 24'h111111; bank[1] = 24'hC00001; bank[2] = 24'h3FFFFE; bank[3] = 24'h876543;
    write_n(0, 4);
    for (int i = 0; i < 10; i++) begin
      wr_valid = 1'b1;
      wr_data  = 24'hDEAD00 + 24'(i);
      tick();
    end
    wr_valid = 1'b0;
    chk("t3_overflow", {31'd0, overflow}, 32'd1);
    chk("t3_drop", {16'd0, drop_count}, 32'd10);
    chk("t3_state", {30'd0, state}, 32'd2);
    drain_bank(1'b0, 1'b1);
    chk("t3_q_empty", 32'(exp_q.size()), 32'd0);
    chk("t3_overflow_sticky", {31'd0, overflow}, 32'd1);

    // Loop replay
    bank[0] = 24'h0A0A0A; bank[1] = 24'hF0F0F0; bank[2] = 24'h000100; bank[3] = 24'h800001;
    br0 = br_count;
    loop_en = 1'b1;
    write_n(0, 4);
    wait_br();
    drain_bank(1'b0, 1'b0);
    chk("t4_idle_valid", {31'd0, rd_valid}, 32'd0);
    chk("t4_idle_br", {31'd0, buffer_ready}, 32'd0);
    chk("t4_idle_state", {30'd0, state}, 32'd1);
    loop_en = 1'b0;
    for (int i = 0; i < DEPTH; i++) exp_q.push_back(bank[i]);
    tick();
    chk("t4_rebr", {31'd0, buffer_ready}, 32'd1);
    chk("t4_revalid", {31'd0, rd_valid}, 32'd1);
    drain_bank(1'b0, 1'b1);
    chk("t4_state_fill", {30'd0, state}, 32'd0);
    chk("t4_br_pulses", 32'(br_count - br0), 32'd2);
    chk("t4_q_empty", 32'(exp_q.size()), 32'd0);

    // Flush after two handshakes; overflow still set from the drop test
    bank[0] = 24'h246802; bank[1] = 24'h13579B; bank[2] = 24'hFEDCBA; bank[3] = 24'h000042;
    write_n(0, 4);
    wait_br();
    rd_ready = 1'b1;
    tick(); tick();
    rd_ready = 1'b0;
    flush    = 1'b1;
    wr_valid = 1'b1;
    wr_data  = 24'h999999;
    tick();
    flush    = 1'b0;
    wr_valid = 1'b0;
    exp_q.delete();
    chk("t5_rd_valid", {31'd0, rd_valid}, 32'd0);
    chk("t5_state", {30'd0, state}, 32'd0);
    chk("t5_level", {29'd0, level}, 32'd0);
    chk("t5_overflow", {31'd0, overflow}, 32'd0);
    chk("t5_drop", {16'd0, drop_count}, 32'd0);
    chk("t5_br", {31'd0, buffer_ready}, 32'd0);
    bank[0] = 24'h765432; bank[1] = 24'h8ACE02; bank[2] = 24'h7F0000; bank[3] = 24'h00FF00;
    write_n(0, 4);
    wait_br();
    drain_bank(1'b0, 1'b1);
    chk("t5_q_empty", 32'(exp_q.size()), 32'd0);

    // Reset mid-fill
    bank[0] = 24'h314159; bank[1] = 24'h271828; bank[2] = 24'h161803; bank[3] = 24'h141421;
    write_n(0, 2);
    exp_q.delete();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_reset_values();
    br0 = br_count;
    write_n(0, 3);
    tick(); tick();
    chk("t6_level3", {29'd0, level}, 32'd3);
    chk("t6_state_fill", {30'd0, state}, 32'd0);
    chk("t6_no_br", 32'(br_count - br0), 32'd0);
    write_n(3, 1);
    wait_br();
    drain_bank(1'b0, 1'b1);
    chk("t6_q_empty", 32'(exp_q.size()), 32'd0);
    chk("t6_br_pulses", 32'(br_count - br0), 32'd1);

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
